onchip_mem_test_master: RTL and testbench
=========================================

# onchip_mem_test_master

Avalon-MM master that exercises the Qsys on-chip memory slave (32-bit, byte-enabled, 15-bit word address, fixed read latency). On a start pulse it fills a configurable word range with an address-derived pattern, then reads the range back and compares each word. It reports pass/fail, the mismatch count and the first failing address. It connects to the memory's s1 port in the DE0-Nano test system as a built-in self-test alongside the Nios memory test software.

## Interface
Parameters:
- DEPTH, 24500: number of implemented memory words; legal addresses are 0..DEPTH-1.
- READ_LATENCY, 1: cycles from read-address cycle to readdata-valid cycle; legal range 1..4.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; honoured only in IDLE or DONE.
- base_addr  in  15  first word address; sampled on accepted start.
- length  in  15  word count (0..DEPTH); sampled on accepted start.
- seed  in  32  pattern seed; sampled on accepted start.
- busy  out  1  high in WRITE, READ and DRAIN.
- done  out  1  high in DONE until the next accepted start or reset.
- pass  out  1  valid while done=1: 1 when cfg_error=0 and error_count=0.
- cfg_error  out  1  range check failed on last start.
- error_count  out  16  mismatches, saturating at 16'hFFFF.
- first_fail_addr  out  15  address of first mismatch; 0 if none.
- avm_address  out  15  word address to memory.
- avm_byteenable  out  4  constant 4'hF.
- avm_chipselect  out  1  high on every write or read cycle.
- avm_write  out  1  write strobe.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data from memory.
- avm_clken  out  1  constant 1.

## Operation
- Pattern: P(a) = seed ^ {~a[14:0], 2'b00, a[14:0]}.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE + start:
  - cfg_error=0, counters cleared.
  - If length==0: go to DONE, pass=1.
  - Else if base_addr+length > DEPTH (16-bit sum, no wrap): go to DONE, cfg_error=1, pass=0, no bus traffic.
  - Else go to WRITE; addr=base_addr, remaining=length.
- WRITE: one write per cycle.
  - avm_chipselect=1, avm_write=1, avm_address=addr, avm_writedata=P(addr).
  - After the last word, reload addr=base_addr and go to READ.
- READ: one read per cycle.
  - avm_chipselect=1, avm_write=0.
  - Push {valid, addr} into a READ_LATENCY-deep tag pipeline.
  - After the last read, go to DRAIN.
- Compare: when a valid tag exits the pipeline, compare avm_readdata with P(tag addr).
  - On mismatch, increment error_count (saturating).
  - On the first mismatch, capture first_fail_addr.
- DRAIN: wait until the pipeline is empty, then go to DONE.
- start while busy: ignored.
- Idle bus: avm_chipselect=0, avm_write=0; avm_address and avm_writedata hold their last value.
- Reset, including mid-operation:
  - State returns to IDLE and the tag pipeline is flushed.
  - Outputs: busy=0, done=0, pass=0, cfg_error=0, error_count=0, first_fail_addr=0, avm_chipselect=0, avm_write=0, avm_address=0, avm_writedata=0.
  - avm_byteenable=4'hF and avm_clken=1 are constant.
- Status outputs keep their value in DONE and are cleared on the next accepted start.

## Timing
- All bus outputs are registered.
- Accepted start edge = cycle 0.
- Writes occupy cycles 1..L.
- Reads occupy cycles L+1..2L.
- A read issued in cycle t has avm_readdata valid in cycle t+READ_LATENCY; it is compared at the edge ending that cycle.
- done=1 from cycle 2L+READ_LATENCY+1; busy=1 in cycles 1..2L+READ_LATENCY.
- length==0 or cfg_error: done=1 in cycle 1, busy never asserts.
- No idle cycle between the last write and the first read; read-after-write to the same address is at least L cycles apart.
- Back-to-back runs: a start in the first DONE cycle begins a new run in the next cycle.

## Test plan
- Clean run, behavioural memory model with READ_LATENCY=1: base=0x0100, length=4, seed=0xA5A5_0000.
  - Writes to 0x100..0x103 in cycles 1-4; first word is 0xA5A5_0000 ^ {15'h7EFF, 2'b00, 15'h0100}.
  - done at cycle 10; pass=1, error_count=0.
- Fault injection: model forces bit 0 of word 0x102 and 0x103 on read.
  - error_count=2, first_fail_addr=0x102, pass=0.
- Boundaries:
  - base=24499, length=1: passes.
  - base=24499, length=2: cfg_error=1, done in cycle 1, avm_chipselect never high.
  - length=0: pass=1 in cycle 1.
- Reset during READ of a length=100 run: all outputs return to reset values the cycle after reset.
  - A subsequent start with length=3 completes with pass=1.
- Sweep READ_LATENCY=1..4, full range base=0, length=24500, seed=0xFFFF_FFFF.
  - done at cycle 49001+READ_LATENCY, pass=1.
  - start pulses during busy are ignored.

Source files
------------

// File: rtl/onchip_mem_test_master_if.sv
// rtl/onchip_mem_test_master_if.sv - Avalon-MM bus between the test master and the on-chip memory s1 port
interface onchip_mem_test_master_if;
  logic [14:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_clken;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
    output avm_readdata
  );
endinterface

// File: rtl/onchip_mem_test_master.sv
// rtl/onchip_mem_test_master.sv - fill/readback self-test master for the on-chip memory
module onchip_mem_test_master #(
  parameter int DEPTH        = 24500,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] base_addr,
  input  logic [14:0] length,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        cfg_error,
  output logic [15:0] error_count,
  output logic [14:0] first_fail_addr,
  onchip_mem_test_master_if.master avm
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t      state;
  logic [14:0] base_r;
  logic [14:0] len_r;
  logic [14:0] rem;
  logic [31:0] seed_r;
  logic        pipe_v [READ_LATENCY];
  logic [14:0] pipe_a [READ_LATENCY];

  logic        mismatch;
  logic        older_empty;
  logic [15:0] range_sum;
  logic        range_bad;

  function automatic logic [31:0] pattern(input logic [31:0] s, input logic [14:0] a);
    return s ^ {~a, 2'b00, a};
  endfunction

  assign avm.avm_byteenable = 4'hF;
  assign avm.avm_clken      = 1'b1;

  always_comb begin
    mismatch    = pipe_v[READ_LATENCY-1] &&
                  (avm.avm_readdata != pattern(seed_r, pipe_a[READ_LATENCY-1]));
    // the last stage is being compared this cycle, so only the younger stages block DONE
    older_empty = 1'b1;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      if (pipe_v[i]) older_empty = 1'b0;
    end
    range_sum = {1'b0, base_addr} + {1'b0, length};
    range_bad = range_sum > DEPTH16;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      base_r             <= '0;
      len_r              <= '0;
      rem                <= '0;
      seed_r             <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      cfg_error          <= 1'b0;
      error_count        <= '0;
      first_fail_addr    <= '0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write      <= 1'b0;
      avm.avm_address    <= '0;
      avm.avm_writedata  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else begin
      // tags follow the registered bus: a read visible this cycle enters stage 0
      pipe_v[0] <= avm.avm_chipselect && !avm.avm_write;
      pipe_a[0] <= avm.avm_address;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end

      if (mismatch) begin
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        if (error_count == 16'd0)    first_fail_addr <= pipe_a[READ_LATENCY-1];
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            cfg_error       <= 1'b0;
            error_count     <= '0;
            first_fail_addr <= '0;
            pass            <= 1'b0;
            seed_r          <= seed;
            base_r          <= base_addr;
            len_r           <= length;
            if (length == 15'd0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else if (range_bad) begin
              state     <= DONE;
              done      <= 1'b1;
              cfg_error <= 1'b1;
            end else begin
              state              <= WRITE;
              done               <= 1'b0;
              busy               <= 1'b1;
              avm.avm_chipselect <= 1'b1;
              avm.avm_write      <= 1'b1;
              avm.avm_address    <= base_addr;
              avm.avm_writedata  <= pattern(seed, base_addr);
              rem                <= length - 15'd1;
            end
          end
        end
        WRITE: begin
          if (rem == 15'd0) begin
            state           <= READ;
            avm.avm_write   <= 1'b0;
            avm.avm_address <= base_r;
            rem             <= len_r - 15'd1;
          end else begin
            avm.avm_address   <= avm.avm_address + 15'd1;
            avm.avm_writedata <= pattern(seed_r, avm.avm_address + 15'd1);
            rem               <= rem - 15'd1;
          end
        end
        READ: begin
          if (rem == 15'd0) begin
            state              <= DRAIN;
            avm.avm_chipselect <= 1'b0;
          end else begin
            avm.avm_address <= avm.avm_address + 15'd1;
            rem             <= rem - 15'd1;
          end
        end
        DRAIN: begin
          if (older_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (error_count == 16'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// tb/tb_onchip_mem_test_master.sv - bench running one master per read latency 1..4 against memory models
module tb_onchip_mem_test_master;
  localparam int DEPTH = 24500;
  localparam int NI    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] base_addr;
  logic [14:0] length;
  logic [31:0] seed;

  logic        fault_en;
  logic [14:0] fa0, fa1;

  logic        busy_w [NI];
  logic        done_w [NI];
  logic        pass_w [NI];
  logic        cfg_w  [NI];
  logic [15:0] err_w  [NI];
  logic [14:0] ffa_w  [NI];
  logic        cs_w   [NI];
  logic        wr_w   [NI];
  logic [14:0] addr_w [NI];
  logic [31:0] wd_w   [NI];
  logic [3:0]  be_w   [NI];
  logic        ck_w   [NI];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int RL = g + 1;
    onchip_mem_test_master_if bus ();
    logic [31:0] mem [DEPTH];
    logic [31:0] sr  [1:RL];

    onchip_mem_test_master #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .length         (length),
      .seed           (seed),
      .busy           (busy_w[g]),
      .done           (done_w[g]),
      .pass           (pass_w[g]),
      .cfg_error      (cfg_w[g]),
      .error_count    (err_w[g]),
      .first_fail_addr(ffa_w[g]),
      .avm            (bus)
    );

    // behavioural memory: data returned RL cycles after the read cycle, bit 0 flipped at fault addresses
    always @(posedge clk) begin
      if (bus.avm_chipselect && bus.avm_write && int'(bus.avm_address) < DEPTH)
        mem[bus.avm_address] <= bus.avm_writedata;
      if (bus.avm_chipselect && !bus.avm_write && int'(bus.avm_address) < DEPTH)
        sr[1] <= mem[bus.avm_address] ^
                 ((fault_en && (bus.avm_address == fa0 || bus.avm_address == fa1)) ? 32'h1 : 32'h0);
      else
        sr[1] <= 32'hDEAD_BEEF;
      for (int j = 2; j <= RL; j++) sr[j] <= sr[j-1];
    end
    assign bus.avm_readdata = sr[RL];

    assign cs_w[g]   = bus.avm_chipselect;
    assign wr_w[g]   = bus.avm_write;
    assign addr_w[g] = bus.avm_address;
    assign wd_w[g]   = bus.avm_writedata;
    assign be_w[g]   = bus.avm_byteenable;
    assign ck_w[g]   = bus.avm_clken;
  end

  function automatic logic [31:0] pat(input logic [31:0] s, input logic [14:0] a);
    return s ^ {~a, 2'b00, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit in_range(input logic [14:0] a, input logic [14:0] b, input logic [14:0] l);
    return int'(a) >= int'(b) && int'(a) < int'(b) + int'(l);
  endfunction

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_status_rl%0d", tag, i + 1),
            {busy_w[i], done_w[i], pass_w[i], cfg_w[i], err_w[i], ffa_w[i]}, 64'd0);
      check($sformatf("%s_bus_rl%0d", tag, i + 1),
            {cs_w[i], wr_w[i], addr_w[i], wd_w[i], be_w[i], ck_w[i]}, {54'd0, 4'hF, 1'b1});
    end
  endtask

  task automatic run(input string tag, input logic [14:0] b, input logic [14:0] l, input logic [31:0] s,
                     input bit fen, input logic [14:0] f0, input logic [14:0] f1, input bit poke);
    int  dcyc [NI];
    int  bcnt [NI];
    int  ccnt [NI];
    int  bad  [NI];
    int  wi   [NI];
    int  ri   [NI];
    bit  exp_cfg, trivial, all_done;
    int  exp_err, budget, exp_ffa;

    exp_cfg = (l != 0) && (int'(b) + int'(l) > DEPTH);
    trivial = (l == 0) || exp_cfg;
    exp_err = 0;
    exp_ffa = 0;
    if (fen && !exp_cfg) begin
      if (in_range(f0, b, l)) exp_err++;
      if (f1 != f0 && in_range(f1, b, l)) exp_err++;
      if (exp_err > 0) begin
        exp_ffa = 32767;
        if (in_range(f0, b, l)) exp_ffa = int'(f0);
        if (in_range(f1, b, l) && int'(f1) < exp_ffa) exp_ffa = int'(f1);
      end
    end

    @(negedge clk);
    base_addr = b; length = l; seed = s;
    fault_en = fen; fa0 = f0; fa1 = f1;
    start = 1'b1;
    for (int i = 0; i < NI; i++) begin
      dcyc[i] = -1; bcnt[i] = 0; ccnt[i] = 0; bad[i] = 0; wi[i] = 0; ri[i] = 0;
    end
    budget = 2 * int'(l) + 20;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start = 1'b0;
      all_done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (busy_w[i]) bcnt[i]++;
        if (cs_w[i]) begin
          ccnt[i]++;
          if (wr_w[i]) begin
            if (int'(addr_w[i]) != int'(b) + wi[i] || wd_w[i] != pat(s, addr_w[i])) bad[i]++;
            wi[i]++;
          end else begin
            if (int'(addr_w[i]) != int'(b) + ri[i]) bad[i]++;
            ri[i]++;
          end
        end
        if (done_w[i] && dcyc[i] < 0) dcyc[i] = k;
        if (dcyc[i] < 0) all_done = 1'b0;
      end
      if (poke && k == 1000) begin
        start = 1'b1; base_addr = 15'd0; length = 15'd5; seed = ~s;
      end
      if (all_done) break;
    end
    start = 1'b0;

    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_done_cycle_rl%0d", tag, i + 1), dcyc[i], trivial ? 1 : 2 * int'(l) + i + 2);
      check($sformatf("%s_busy_cycles_rl%0d", tag, i + 1), bcnt[i], trivial ? 0 : 2 * int'(l) + i + 1);
      check($sformatf("%s_bus_cycles_rl%0d", tag, i + 1), ccnt[i], trivial ? 0 : 2 * int'(l));
      check($sformatf("%s_bad_bus_rl%0d", tag, i + 1), bad[i], 0);
      check($sformatf("%s_pass_rl%0d", tag, i + 1), pass_w[i], !exp_cfg && exp_err == 0);
      check($sformatf("%s_cfg_error_rl%0d", tag, i + 1), cfg_w[i], exp_cfg);
      check($sformatf("%s_error_count_rl%0d", tag, i + 1), err_w[i], exp_err);
      check($sformatf("%s_first_fail_rl%0d", tag, i + 1), ffa_w[i], exp_ffa);
    end
  endtask

  task automatic reset_mid_read();
    @(negedge clk);
    base_addr = 15'd2000; length = 15'd100; seed = 32'h1234_5678;
    fault_en = 1'b1; fa0 = 15'd2000; fa1 = 15'd2000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (149) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("pre_reset_busy_rl%0d", i + 1), busy_w[i], 1'b1);
      check($sformatf("pre_reset_err_rl%0d", i + 1), err_w[i], 16'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("mid_reset");
    reset = 1'b0;
    fault_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; seed = '0;
    fault_en = 1'b0; fa0 = '0; fa1 = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    run("clean", 15'h0100, 15'd4, 32'hA5A5_0000, 1'b0, 15'd0, 15'd0, 1'b0);
    check("first_pattern_word", pat(32'hA5A5_0000, 15'h0100), 32'hA5A5_0000 ^ {15'h7EFF, 2'b00, 15'h0100});
    run("fault", 15'h0100, 15'd4, 32'hA5A5_0000, 1'b1, 15'h0102, 15'h0103, 1'b0);
    run("top_ok", 15'd24499, 15'd1, $urandom, 1'b0, 15'd0, 15'd0, 1'b0);
    run("top_cfg", 15'd24499, 15'd2, $urandom, 1'b0, 15'd0, 15'd0, 1'b0);
    run("len0", 15'd77, 15'd0, $urandom, 1'b0, 15'd0, 15'd0, 1'b0);
    reset_mid_read();
    run("after_reset", 15'd300, 15'd3, $urandom, 1'b0, 15'd0, 15'd0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      logic [14:0] b, l, f0, f1;
      if ($urandom_range(0, 3) == 0) begin
        b = 15'(DEPTH - int'($urandom_range(0, 100)));
        l = 15'($urandom_range(0, 150));
      end else begin
        b = 15'($urandom_range(0, 24000));
        l = 15'($urandom_range(1, 200));
      end
      f0 = b + 15'($urandom_range(0, 205));
      f1 = b + 15'($urandom_range(0, 205));
      run($sformatf("rand%0d", r), b, l, $urandom, 1'($urandom_range(0, 1)), f0, f1, 1'b0);
    end

    run("sweep", 15'd0, 15'd24500, 32'hFFFF_FFFF, 1'b0, 15'd0, 15'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
